alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Handshaked, parametrised ALU for the pipelined datapath. Executes the ISA
//  ALU ops (add/sub/logic/shift/rotate/compare/bit-reverse) in one cycle and
//  adds iterative unsigned MUL/DIVU/REMU (WIDTH cycles, 1 bit per cycle).
//  Sits between decode/issue (producer) and writeback (consumer); operands
//  and flags are registered.
// PARAMETERS
//  WIDTH    16                operand/result width, >=4, power of two
//  SHW      $clog2(WIDTH)     shift-amount width, derived, do not override
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active-low
//  flush      in   1      synchronous abort of any in-flight op
//  in_valid   in   1      op/operands valid
//  in_ready   out  1      unit can accept (state IDLE)
//  op         in   4      operation code (see BEHAVIOUR)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (shift amount = b[SHW-1:0])
//  out_valid  out  1      result valid (state DONE)
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  registered result
//  ofl        out  1      overflow flag
//  zero       out  1      result == 0
//  div0       out  1      DIVU/REMU with b == 0
// BEHAVIOUR
//  Ops: 0 ADD a+b; 1 SUB b-a; 2 XOR; 3 ANDN a&~b; 4 SLL; 5 SRL (zero fill);
//   6 ROL; 7 ROR; 8 SEQ a==b; 9 SLT a<b signed; A SLE a<=b signed;
//   B SCO carry-out of a+b; C BTR bit-reverse a; D MUL low WIDTH of a*b
//   unsigned; E DIVU a/b; F REMU a%b. Compare ops return 0 or 1 zero-extended.
//  States: IDLE -> (in_valid) -> DONE for ops 0-C; IDLE -> BUSY for D-F;
//   BUSY -> DONE after exactly WIDTH iterations; DONE -> IDLE when out_ready.
//  in_ready = (state==IDLE); out_valid = (state==DONE). No accept in the
//   cycle a result is drained (DONE->IDLE first); throughput 1 op / 2 cycles.
//  Latency from accept edge: ops 0-C out_valid next cycle; D-F WIDTH+1 cycles.
//  Operands captured at accept; a/b/op may change afterwards.
//  result/flags stable while out_valid && !out_ready (backpressure holds).
//  ofl: ADD/SUB signed overflow; MUL set if upper WIDTH product bits != 0;
//   all other ops 0. zero computed from final result for every op.
//  MUL: shift-add, 2*WIDTH accumulator. DIVU/REMU: restoring, WIDTH+1-bit
//   partial remainder.
//  b==0 on E/F: no iteration, DONE next cycle, result DIVU=all ones,
//   REMU=a, div0=1; div0 is 0 for every other result.
//  Shift/rotate amounts >= WIDTH impossible (SHW bits); amount 0 passes a.
//  flush: any state -> IDLE next cycle, result discarded, outputs cleared;
//   flush wins over in_valid and out_ready in the same cycle (no accept).
//  Reset (rst_n low, any time incl. mid-BUSY): state IDLE, result=0, ofl=0,
//   zero=0, div0=0, out_valid=0, in_ready=1 after release.
// TESTING
//  ADD a=7FFF b=0001 -> result 8000, ofl=1, zero=0, out_valid 1 cycle after
//   accept; SUB a=5 b=5 -> 0000, zero=1.
//  MUL a=0123 b=0010 -> 1230, ofl=0, out_valid exactly 17 cycles after
//   accept; MUL a=FFFF b=0002 -> FFFE, ofl=1.
//  DIVU a=0064 b=0007 -> 000E; REMU same -> 0002; DIVU b=0 -> FFFF, div0=1
//   in 1 cycle; REMU a=1234 b=0 -> 1234, div0=1.
//  ROR a=8001 b=1 -> C000; ROL a=8001 b=4 -> 0018; SLT a=FFFF b=0001 -> 1;
//   BTR a=0001 -> 8000; SCO a=FFFF b=0001 -> 0001.
//  Backpressure: ADD completes, out_ready low 5 cycles -> result/flags
//   constant, in_ready=0; out_ready high -> IDLE next cycle, in_ready=1.
//  Abort: rst_n low 8 cycles into MUL -> all outputs 0 immediately; flush
//   during BUSY with in_valid high -> IDLE next cycle, no op accepted, no
//   out_valid pulse.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Handshaked ALU with single-cycle ops and iterative MUL/DIVU/REMU.
// Revision    : 1.0  initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ofl,
    output logic             zero,
    output logic             div0
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_XOR  = 4'h2;
    localparam logic [3:0] OP_ANDN = 4'h3;
    localparam logic [3:0] OP_SLL  = 4'h4;
    localparam logic [3:0] OP_SRL  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_SEQ  = 4'h8;
    localparam logic [3:0] OP_SLT  = 4'h9;
    localparam logic [3:0] OP_SLE  = 4'hA;
    localparam logic [3:0] OP_SCO  = 4'hB;
    localparam logic [3:0] OP_BTR  = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;
    localparam logic [3:0] OP_DIVU = 4'hE;
    localparam logic [3:0] OP_REMU = 4'hF;

    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 ofl_q, ofl_d;
    logic                 zero_q, zero_d;
    logic                 div0_q, div0_d;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live operands at accept
    // ------------------------------------------------------------------
    logic [SHW-1:0]       w_sh;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_diff;
    logic [2*WIDTH-1:0]   w_rol_ext;
    logic [2*WIDTH-1:0]   w_ror_ext;
    logic [WIDTH-1:0]     w_btr;
    logic [WIDTH-1:0]     w_fast_res;
    logic                 w_fast_ofl;
    logic                 w_iter_op;

    assign w_sh      = b[SHW-1:0];
    assign w_sum     = {1'b0, a} + {1'b0, b};
    assign w_diff    = b - a;
    assign w_rol_ext = {a, a} << w_sh;
    assign w_ror_ext = {a, a} >> w_sh;
    assign w_iter_op = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_btr
        assign w_btr[gi] = a[WIDTH-1-gi];
    end

    always_comb begin
        w_fast_res = '0;
        w_fast_ofl = 1'b0;
        case (op)
            OP_ADD: begin
                w_fast_res = w_sum[WIDTH-1:0];
                w_fast_ofl = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_fast_res = w_diff;
                w_fast_ofl = (b[WIDTH-1] != a[WIDTH-1]) && (w_diff[WIDTH-1] != b[WIDTH-1]);
            end
            OP_XOR:  w_fast_res = a ^ b;
            OP_ANDN: w_fast_res = a & ~b;
            OP_SLL:  w_fast_res = a << w_sh;
            OP_SRL:  w_fast_res = a >> w_sh;
            OP_ROL:  w_fast_res = w_rol_ext[2*WIDTH-1:WIDTH];
            OP_ROR:  w_fast_res = w_ror_ext[WIDTH-1:0];
            OP_SEQ:  w_fast_res = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_SLT:  w_fast_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLE:  w_fast_res = {{(WIDTH-1){1'b0}}, ($signed(a) <= $signed(b))};
            OP_SCO:  w_fast_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH]};
            OP_BTR:  w_fast_res = w_btr;
            default: w_fast_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative step logic: MUL keeps {partial product, multiplier} in acc,
    // DIVU/REMU keep the shifting dividend/quotient in acc[WIDTH-1:0].
    // ------------------------------------------------------------------
    logic [WIDTH:0]       w_mul_add;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_sh;
    logic [WIDTH:0]       w_div_trial;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_rem_next;
    logic [WIDTH-1:0]     w_quo_next;

    assign w_mul_add   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign w_mul_next  = {w_mul_add, acc_q[WIDTH-1:1]};
    assign w_div_sh    = {rem_q, acc_q[WIDTH-1]};
    assign w_div_trial = w_div_sh - {1'b0, b_q};
    assign w_div_ge    = ~w_div_trial[WIDTH];
    assign w_rem_next  = w_div_ge ? w_div_trial[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
    assign w_quo_next  = {acc_q[WIDTH-2:0], w_div_ge};

    // ------------------------------------------------------------------
    // Control FSM and result/flag next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        ofl_d    = ofl_q;
        zero_d   = zero_q;
        div0_d   = div0_q;

        if (flush) begin
            state_d  = S_IDLE;
            result_d = '0;
            ofl_d    = 1'b0;
            zero_d   = 1'b0;
            div0_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_iter_op && (op != OP_MUL) && (b == '0)) begin
                            state_d  = S_DONE;
                            result_d = (op == OP_DIVU) ? {WIDTH{1'b1}} : a;
                            ofl_d    = 1'b0;
                            zero_d   = (op == OP_REMU) && (a == '0);
                            div0_d   = 1'b1;
                        end else if (w_iter_op) begin
                            state_d = S_BUSY;
                            op_d    = op;
                            a_d     = a;
                            b_d     = b;
                            cnt_d   = '0;
                            acc_d   = (op == OP_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
                            rem_d   = '0;
                        end else begin
                            state_d  = S_DONE;
                            result_d = w_fast_res;
                            ofl_d    = w_fast_ofl;
                            zero_d   = (w_fast_res == '0);
                            div0_d   = 1'b0;
                        end
                    end
                end
                S_BUSY: begin
                    cnt_d = cnt_q + 1'b1;
                    if (op_q == OP_MUL) begin
                        acc_d = w_mul_next;
                    end else begin
                        acc_d = {acc_q[2*WIDTH-1:WIDTH], w_quo_next};
                        rem_d = w_rem_next;
                    end
                    // Last iteration writes the result straight from the step value
                    if (cnt_q == LAST_ITER) begin
                        state_d = S_DONE;
                        div0_d  = 1'b0;
                        case (op_q)
                            OP_MUL: begin
                                result_d = w_mul_next[WIDTH-1:0];
                                ofl_d    = |w_mul_next[2*WIDTH-1:WIDTH];
                                zero_d   = (w_mul_next[WIDTH-1:0] == '0);
                            end
                            OP_DIVU: begin
                                result_d = w_quo_next;
                                ofl_d    = 1'b0;
                                zero_d   = (w_quo_next == '0);
                            end
                            default: begin
                                result_d = w_rem_next;
                                ofl_d    = 1'b0;
                                zero_d   = (w_rem_next == '0);
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            ofl_q    <= 1'b0;
            zero_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            ofl_q    <= ofl_d;
            zero_q   <= zero_d;
            div0_q   <= div0_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign ofl       = ofl_q;
    assign zero      = zero_q;
    assign div0      = div0_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed-vector bench for alu_seq (WIDTH=16).
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq;

    localparam int W  = 16;
    localparam int NV = 28;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         ofl;
    logic         zero;
    logic         div0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ofl       (ofl),
        .zero      (zero),
        .div0      (div0)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ofl;
        logic         zero;
        logic         div0;
        int           lat;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Accept one op, measure latency to out_valid, compare, then drain
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        op = v.op; a = v.a; b = v.b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(v.lat));
        chk({tag, " result"}, {16'd0, result}, {16'd0, v.res});
        chk({tag, " ofl"}, {31'd0, ofl}, {31'd0, v.ofl});
        chk({tag, " zero"}, {31'd0, zero}, {31'd0, v.zero});
        chk({tag, " div0"}, {31'd0, div0}, {31'd0, v.div0});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        vec_t t;
        bit   seen;
        //            op     a        b        res      ofl   zero  div0  lat
        vecs[0]  = '{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0, 1};
        vecs[1]  = '{4'h1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0, 1};
        vecs[2]  = '{4'h1, 16'h0001, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1};
        vecs[3]  = '{4'h0, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1};
        vecs[4]  = '{4'h2, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1};
        vecs[5]  = '{4'h3, 16'hF0F0, 16'hFF00, 16'h00F0, 1'b0, 1'b0, 1'b0, 1};
        vecs[6]  = '{4'h4, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 1'b0, 1};
        vecs[7]  = '{4'h5, 16'h8000, 16'h0010, 16'h8000, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{4'h5, 16'h8000, 16'h0003, 16'h1000, 1'b0, 1'b0, 1'b0, 1};
        vecs[9]  = '{4'h7, 16'h8001, 16'h0001, 16'hC000, 1'b0, 1'b0, 1'b0, 1};
        vecs[10] = '{4'h6, 16'h8001, 16'h0004, 16'h0018, 1'b0, 1'b0, 1'b0, 1};
        vecs[11] = '{4'h8, 16'h1234, 16'h1234, 16'h0001, 1'b0, 1'b0, 1'b0, 1};
        vecs[12] = '{4'h8, 16'h1234, 16'h1235, 16'h0000, 1'b0, 1'b1, 1'b0, 1};
        vecs[13] = '{4'h9, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1};
        vecs[14] = '{4'h9, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1};
        vecs[15] = '{4'hA, 16'h0005, 16'h0005, 16'h0001, 1'b0, 1'b0, 1'b0, 1};
        vecs[16] = '{4'hB, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1};
        vecs[17] = '{4'hB, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 1};
        vecs[18] = '{4'hC, 16'h0001, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b0, 1};
        vecs[19] = '{4'hD, 16'h0123, 16'h0010, 16'h1230, 1'b0, 1'b0, 1'b0, 17};
        vecs[20] = '{4'hD, 16'hFFFF, 16'h0002, 16'hFFFE, 1'b1, 1'b0, 1'b0, 17};
        vecs[21] = '{4'hD, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 17};
        vecs[22] = '{4'hE, 16'h0064, 16'h0007, 16'h000E, 1'b0, 1'b0, 1'b0, 17};
        vecs[23] = '{4'hF, 16'h0064, 16'h0007, 16'h0002, 1'b0, 1'b0, 1'b0, 17};
        vecs[24] = '{4'hE, 16'h0064, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1};
        vecs[25] = '{4'hF, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b1, 1};
        vecs[26] = '{4'hE, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 17};
        vecs[27] = '{4'hF, 16'h0003, 16'h0007, 16'h0003, 1'b0, 1'b0, 1'b0, 17};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset result", {16'd0, result}, 32'd0);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset flags", {29'd0, ofl, zero, div0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Backpressure: result held, no accept while DONE, drain takes a cycle
        @(negedge clk);
        op = 4'h0; a = 16'h7FFF; b = 16'h0001; in_valid = 1'b1;
        @(posedge clk);
        #1;
        op = 4'h2; a = 16'h0F0F; b = 16'h0F0F;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d result", i), {16'd0, result}, 32'h8000);
            chk($sformatf("bp%0d ofl/valid/ready", i), {29'd0, ofl, out_valid, in_ready}, 32'b110);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("bp drain valid/ready", {30'd0, out_valid, in_ready}, 32'b01);
        @(posedge clk);
        #1;
        chk("bp no accept on drain", {30'd0, out_valid, in_ready}, 32'b01);

        // Reset 8 cycles into MUL clears outputs that are currently non-zero
        @(negedge clk);
        op = 4'hD; a = 16'h0123; b = 16'h0010; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst mid-mul result", {16'd0, result}, 32'd0);
        chk("rst mid-mul flags", {28'd0, out_valid, ofl, zero, div0}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst release in_ready", {31'd0, in_ready}, 32'd1);

        t = '{4'h0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1};
        run_vec(t, "post-rst add");

        // Flush during BUSY with in_valid asserted: no accept, no result
        @(negedge clk);
        op = 4'hD; a = 16'h0123; b = 16'h0010; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 4'h0; a = 16'h0001; b = 16'h0001;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush result", {16'd0, result}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("flush no out_valid pulse", {31'd0, seen}, 32'd0);

        t = '{4'hE, 16'h0064, 16'h0007, 16'h000E, 1'b0, 1'b0, 1'b0, 17};
        run_vec(t, "post-flush divu");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
